// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Opcodes, FSM encoding and error bit positions shared by the
//               ALU op sequencer files.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;

    localparam int ERR_OVF     = 0;
    localparam int ERR_DIV0    = 1;
    localparam int ERR_ILLEGAL = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Command and response valid/ready channels of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_use_acc;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_error
    );

endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer_settle.sv
`default_nettype none
// ============================================================================
// Module      : op_settle_counter
// Description : Loadable down counter with zero flag; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module op_settle_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             dec,
    output logic      [WIDTH-1:0] count,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Multi-cycle controller holding operands stable in front of a
//               combinational ALU and returning result/error over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 6,
    parameter int LAT_DIV = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_op_sequencer_if.slave bus,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic [3:0]        alu_opcode,
    input  wire logic [31:0]  alu_result,
    input  wire logic [1:0]   alu_error,
    output logic [15:0]       acc,
    output logic [2:0]        sticky_err,
    input  wire logic         err_clr
);

    localparam int LAT_MAX_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int LAT_MAX    = (LAT_MAX_AM > LAT_DIV) ? LAT_MAX_AM : LAT_DIV;
    localparam int CNT_W      = $clog2(LAT_MAX) + 1;

    seq_state_t  r_state;
    seq_state_t  w_state_next;

    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [3:0]  r_alu_opcode;
    logic [31:0] r_rsp_result;
    logic [2:0]  r_rsp_error;
    logic [15:0] r_acc;
    logic [2:0]  r_sticky;

    logic             w_launch;
    logic             w_illegal;
    logic             w_capture;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_val;
    logic [CNT_W-1:0] w_load_val;
    logic [2:0]       w_new_err;

    // Counter starts at LAT-1 so the capture lands on the LAT-th edge after accept
    always_comb begin
        w_load_val = CNT_W'(LAT_DIV - 1);
        case (bus.cmd_op)
            OP_ADD, OP_SUB: w_load_val = CNT_W'(LAT_ADD - 1);
            OP_MUL:         w_load_val = CNT_W'(LAT_MUL - 1);
            default:        w_load_val = CNT_W'(LAT_DIV - 1);
        endcase
    end

    op_settle_counter #(
        .WIDTH (CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (w_load_val),
        .dec      (w_cnt_dec),
        .count    (w_cnt_val),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_illegal    = 1'b0;
        w_capture    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (op_is_legal(bus.cmd_op)) begin
                        w_launch     = 1'b1;
                        w_cnt_load   = 1'b1;
                        w_state_next = ST_EXEC;
                    end else begin
                        w_illegal    = 1'b1;
                        w_state_next = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (w_cnt_zero) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_new_err = 3'b000;
        if (w_capture) begin
            w_new_err = {1'b0, alu_error};
        end else if (w_illegal) begin
            w_new_err[ERR_ILLEGAL] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_rsp_result <= '0;
            r_rsp_error  <= '0;
            r_acc        <= '0;
            r_sticky     <= '0;
        end else begin
            if (w_launch) begin
                r_alu_a      <= bus.cmd_use_acc ? r_acc : bus.cmd_a;
                r_alu_b      <= bus.cmd_b;
                r_alu_opcode <= bus.cmd_op;
            end
            if (w_capture) begin
                r_rsp_result <= alu_result;
                r_rsp_error  <= {1'b0, alu_error};
                if (alu_error == 2'b00) begin
                    r_acc <= alu_result[15:0];
                end
            end else if (w_illegal) begin
                r_rsp_result <= '0;
                r_rsp_error  <= w_new_err;
            end
            // A clear coinciding with a new error keeps only the new bits
            r_sticky <= (err_clr ? 3'b000 : r_sticky) | w_new_err;
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_error  = r_rsp_error;
    assign alu_a          = r_alu_a;
    assign alu_b          = r_alu_b;
    assign alu_opcode     = r_alu_opcode;
    assign acc            = r_acc;
    assign sticky_err     = r_sticky;

endmodule
`default_nettype wire
